// File: rtl/sii_ncu_mon_pkg.sv
// Shared types for the SII->NCU transfer monitor: channel FSM states,
// error codes and the parity slice width.
package sii_ncu_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_GAP  = 3'd2,
      ST_HDR  = 3'd3,
      ST_PLD  = 3'd4
   } chan_state_e;

   typedef logic [2:0] err_code_t;

   localparam err_code_t ERR_NONE        = 3'd0;
   localparam err_code_t ERR_GNT_NO_REQ  = 3'd1;
   localparam err_code_t ERR_REQ_DROP    = 3'd2;
   localparam err_code_t ERR_TIMEOUT     = 3'd3;
   localparam err_code_t ERR_GNT_OVERLAP = 3'd4;
   localparam err_code_t ERR_PARITY      = 3'd5;

   localparam int PAR_SLICE = 16;

endpackage

// File: rtl/sii_ncu_xfer_chan.sv
// One monitored req/gnt channel: handshake FSM, packet capture, timeout,
// packet counter and (with SII_NCU_XFER_MON_PARITY_EN) payload parity check.
module sii_ncu_xfer_chan
   import sii_ncu_mon_pkg::*;
#(
   parameter int DW     = 32,
   parameter int PW     = DW / PAR_SLICE,
   parameter int NBEATS = 4,
   parameter int TMO_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                 iol2clk_i,
   input  logic                 iol2rst_i,
   input  logic                 enable_i,
   input  logic                 req_i,
   input  logic                 gnt_i,
   input  logic [DW-1:0]        data_i,
   input  logic [PW-1:0]        dparity_i,
   input  logic [TMO_W-1:0]     tmo_limit_i,
   output logic                 pkt_vld_o,
   output logic [DW-1:0]        pkt_hdr_o,
   output logic [NBEATS*DW-1:0] pkt_pld_o,
   output logic                 err_pulse_o,
   output logic [2:0]           err_code_o,
   output logic [CNT_W-1:0]     xfer_cnt_o
);

   localparam int BW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int PLDW = NBEATS * DW;

   chan_state_e       state_q, state_d;
   logic [BW-1:0]     beat_q;
   logic [TMO_W-1:0]  tmo_cnt_q;
   logic              tmo_flag_q;
   logic [DW-1:0]     hdr_buf_q;
   logic [PLDW-1:0]   pld_buf_q, pld_buf_d;
   logic              pkt_vld_q, err_pulse_q;
   logic [DW-1:0]     pkt_hdr_q;
   logic [PLDW-1:0]   pkt_pld_q;
   err_code_t         err_code_q, err_d;
   logic [CNT_W-1:0]  cnt_q;

   logic last_beat, tmo_hit, par_err;
   logic err_vld, hdr_cap, beat_cap, pkt_done;

   assign last_beat = (beat_q == BW'(NBEATS - 1));
   // Equality fires once per REQ episode even if the counter sits saturated at the limit.
   assign tmo_hit   = (state_q == ST_REQ) && (tmo_limit_i != '0) &&
                      (tmo_cnt_q == tmo_limit_i) && !tmo_flag_q;

`ifdef SII_NCU_XFER_MON_PARITY_EN
   logic [PW-1:0] par_mis;
   for (genvar gi = 0; gi < PW; gi++) begin : g_par
      assign par_mis[gi] = dparity_i[gi] ^ (^data_i[gi*PAR_SLICE +: PAR_SLICE]);
   end
   assign par_err = |par_mis;
`else
   logic unused_dparity;
   assign unused_dparity = ^dparity_i;
   assign par_err = 1'b0;
`endif

   always_ff @(posedge iol2clk_i) begin
      if (iol2rst_i || !enable_i) state_q <= ST_IDLE;
      else                        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_i) state_d = gnt_i ? ST_GAP : ST_REQ;
         ST_REQ: begin
            if (gnt_i)       state_d = ST_GAP;
            else if (!req_i) state_d = ST_IDLE;
         end
         ST_GAP:  state_d = ST_HDR;
         ST_HDR:  state_d = ST_PLD;
         ST_PLD:  if (last_beat) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Checks are ordered by ascending code so the higher code wins a collision.
   always_comb begin
      err_vld  = 1'b0;
      err_d    = ERR_NONE;
      hdr_cap  = 1'b0;
      beat_cap = 1'b0;
      pkt_done = 1'b0;
      case (state_q)
         ST_IDLE: if (!req_i && gnt_i) begin err_vld = 1'b1; err_d = ERR_GNT_NO_REQ; end
         ST_REQ: begin
            if (!req_i && !gnt_i) begin err_vld = 1'b1; err_d = ERR_REQ_DROP; end
            if (tmo_hit)          begin err_vld = 1'b1; err_d = ERR_TIMEOUT;  end
         end
         ST_GAP, ST_HDR, ST_PLD: begin
            hdr_cap  = (state_q == ST_HDR);
            beat_cap = (state_q == ST_PLD);
            pkt_done = (state_q == ST_PLD) && last_beat;
            if (gnt_i)               begin err_vld = 1'b1; err_d = ERR_GNT_OVERLAP; end
            if (beat_cap && par_err) begin err_vld = 1'b1; err_d = ERR_PARITY;      end
         end
         default: ;
      endcase
   end

   for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
      assign pld_buf_d[gi*DW +: DW] = (beat_cap && beat_q == BW'(gi)) ? data_i
                                                                      : pld_buf_q[gi*DW +: DW];
   end

   always_ff @(posedge iol2clk_i) begin
      if (iol2rst_i) begin
         beat_q      <= '0;
         tmo_cnt_q   <= '0;
         tmo_flag_q  <= 1'b0;
         hdr_buf_q   <= '0;
         pld_buf_q   <= '0;
         pkt_vld_q   <= 1'b0;
         err_pulse_q <= 1'b0;
         pkt_hdr_q   <= '0;
         pkt_pld_q   <= '0;
         err_code_q  <= ERR_NONE;
         cnt_q       <= '0;
      end else if (!enable_i) begin
         pkt_vld_q   <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         pkt_vld_q   <= pkt_done;
         err_pulse_q <= err_vld;
         if (err_vld) err_code_q <= err_d;
         if (hdr_cap) begin
            hdr_buf_q <= data_i;
            beat_q    <= '0;
         end
         if (beat_cap) begin
            pld_buf_q <= pld_buf_d;
            beat_q    <= beat_q + 1'b1;
         end
         // Last beat goes straight from the bus into the held payload.
         if (pkt_done) begin
            pkt_hdr_q <= hdr_buf_q;
            pkt_pld_q <= pld_buf_d;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
         end
         if (state_q == ST_REQ) begin
            if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_hit)         tmo_flag_q <= 1'b1;
         end else begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
         end
      end
   end

   assign pkt_vld_o   = pkt_vld_q;
   assign pkt_hdr_o   = pkt_hdr_q;
   assign pkt_pld_o   = pkt_pld_q;
   assign err_pulse_o = err_pulse_q;
   assign err_code_o  = err_code_q;
   assign xfer_cnt_o  = cnt_q;

endmodule

// File: rtl/sii_ncu_xfer_mon.sv
// Passive NCH-channel SII->NCU transfer monitor; one sii_ncu_xfer_chan per channel.
// Define SII_NCU_XFER_MON_PARITY_EN to enable payload parity checking.
module sii_ncu_xfer_mon
   import sii_ncu_mon_pkg::*;
#(
   parameter int NCH    = 1,
   parameter int DW     = 32,
   parameter int PW     = DW / PAR_SLICE,
   parameter int NBEATS = 4,
   parameter int TMO_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                     iol2clk,
   input  logic                     iol2rst,
   input  logic                     enable,
   input  logic [NCH-1:0]           req,
   input  logic [NCH-1:0]           gnt,
   input  logic [NCH*DW-1:0]        data,
   input  logic [NCH*PW-1:0]        dparity,
   input  logic [TMO_W-1:0]         tmo_limit,
   output logic [NCH-1:0]           pkt_vld,
   output logic [NCH*DW-1:0]        pkt_hdr,
   output logic [NCH*NBEATS*DW-1:0] pkt_pld,
   output logic [NCH-1:0]           err_pulse,
   output logic [NCH*3-1:0]         err_code,
   output logic [NCH*CNT_W-1:0]     xfer_cnt
);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      sii_ncu_xfer_chan #(
         .DW     (DW),
         .PW     (PW),
         .NBEATS (NBEATS),
         .TMO_W  (TMO_W),
         .CNT_W  (CNT_W)
      ) u_chan (
         .iol2clk_i   (iol2clk),
         .iol2rst_i   (iol2rst),
         .enable_i    (enable),
         .req_i       (req[gi]),
         .gnt_i       (gnt[gi]),
         .data_i      (data[gi*DW +: DW]),
         .dparity_i   (dparity[gi*PW +: PW]),
         .tmo_limit_i (tmo_limit),
         .pkt_vld_o   (pkt_vld[gi]),
         .pkt_hdr_o   (pkt_hdr[gi*DW +: DW]),
         .pkt_pld_o   (pkt_pld[gi*NBEATS*DW +: NBEATS*DW]),
         .err_pulse_o (err_pulse[gi]),
         .err_code_o  (err_code[gi*3 +: 3]),
         .xfer_cnt_o  (xfer_cnt[gi*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_sii_ncu_xfer_mon.sv
// Scoreboard bench for sii_ncu_xfer_mon (NCH=2, NBEATS=4): expected packets and
// error events are queued as stimulus is driven and checked when the DUT reports them.
module tb_sii_ncu_xfer_mon;

   localparam int NCH = 2, DW = 32, PW = 2, NBEATS = 4, TMO_W = 8, CNT_W = 16;
   localparam int PLDW = NBEATS * DW;

   logic                     iol2clk = 1'b0;
   logic                     iol2rst = 1'b1;
   logic                     enable  = 1'b0;
   logic [NCH-1:0]           req     = '0;
   logic [NCH-1:0]           gnt     = '0;
   logic [NCH*DW-1:0]        data    = '0;
   logic [NCH*PW-1:0]        dparity = '0;
   logic [TMO_W-1:0]         tmo_limit = '0;
   logic [NCH-1:0]           pkt_vld;
   logic [NCH*DW-1:0]        pkt_hdr;
   logic [NCH*PLDW-1:0]      pkt_pld;
   logic [NCH-1:0]           err_pulse;
   logic [NCH*3-1:0]         err_code;
   logic [NCH*CNT_W-1:0]     xfer_cnt;

   sii_ncu_xfer_mon #(
      .NCH(NCH), .DW(DW), .PW(PW), .NBEATS(NBEATS), .TMO_W(TMO_W), .CNT_W(CNT_W)
   ) dut (
      .iol2clk(iol2clk), .iol2rst(iol2rst), .enable(enable),
      .req(req), .gnt(gnt), .data(data), .dparity(dparity), .tmo_limit(tmo_limit),
      .pkt_vld(pkt_vld), .pkt_hdr(pkt_hdr), .pkt_pld(pkt_pld),
      .err_pulse(err_pulse), .err_code(err_code), .xfer_cnt(xfer_cnt)
   );

   always #5 iol2clk = ~iol2clk;

   int cyc = 0;
   always @(posedge iol2clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int               ch;
      int               edge_no;
      logic [DW-1:0]    hdr;
      logic [PLDW-1:0]  pld;
      logic [CNT_W-1:0] cnt;
   } pkt_t;

   typedef struct {
      int         ch;
      int         edge_no;
      logic [2:0] code;
   } err_t;

   pkt_t pq[$];
   err_t eq[$];
   pkt_t mon_p;
   err_t mon_e;
   logic [CNT_W-1:0] exp_cnt [NCH];

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: one line per reported transaction, checked against the queue heads.
   always @(negedge iol2clk) begin
      if (!iol2rst) begin
         for (int c = 0; c < NCH; c++) begin
            if (pkt_vld[c]) begin
               if (pq.size() == 0) chk("pkt_unexpected", 256'(pkt_vld[c]), 256'(0));
               else begin
                  mon_p = pq.pop_front();
                  $display("cyc %0d ch%0d pkt hdr=%08h cnt=%0d", cyc, c,
                           pkt_hdr[c*DW +: DW], xfer_cnt[c*CNT_W +: CNT_W]);
                  chk("pkt_ch",    256'(c),                          256'(mon_p.ch));
                  chk("pkt_cycle", 256'(cyc),                        256'(mon_p.edge_no));
                  chk("pkt_hdr",   256'(pkt_hdr[c*DW +: DW]),        256'(mon_p.hdr));
                  chk("pkt_pld",   256'(pkt_pld[c*PLDW +: PLDW]),    256'(mon_p.pld));
                  chk("pkt_cnt",   256'(xfer_cnt[c*CNT_W +: CNT_W]), 256'(mon_p.cnt));
               end
            end
            if (err_pulse[c]) begin
               if (eq.size() == 0) chk("err_unexpected", 256'(err_pulse[c]), 256'(0));
               else begin
                  mon_e = eq.pop_front();
                  $display("cyc %0d ch%0d err code=%0d", cyc, c, err_code[c*3 +: 3]);
                  chk("err_ch",    256'(c),                 256'(mon_e.ch));
                  chk("err_cycle", 256'(cyc),               256'(mon_e.edge_no));
                  chk("err_code",  256'(err_code[c*3 +: 3]), 256'(mon_e.code));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge iol2clk);
      #1;
   endtask

   function automatic logic [PW-1:0] par(input logic [DW-1:0] d);
      return {^d[31:16], ^d[15:0]};
   endfunction

   task automatic put(input int ch, input logic [DW-1:0] d, input bit flip);
      data[ch*DW +: DW]    = d;
      dparity[ch*PW +: PW] = par(d) ^ {1'b0, flip};
   endtask

   task automatic push_err(input int ch, input int edge_no, input logic [2:0] code);
      err_t e;
      e.ch = ch; e.edge_no = edge_no; e.code = code;
      eq.push_back(e);
   endtask

   // nwait: cycles of req before gnt; ovl/par/rst_beat: beat index for the fault, -1 for none.
   task automatic send_pkt(input int ch, input int nwait, input logic [DW-1:0] hdr,
                           input logic [PLDW-1:0] pld, input int ovl_beat,
                           input int par_beat, input int rst_beat);
      int   r, g;
      bit   aborted;
      pkt_t p;
      aborted = 1'b0;
      req[ch] = 1'b1;
      r = cyc + 1;
      if (tmo_limit != 0 && nwait >= int'(tmo_limit) + 1)
         push_err(ch, r + int'(tmo_limit) + 1, 3'd3);
      repeat (nwait) tick();
      gnt[ch] = 1'b1;
      g = cyc + 1;
      if (rst_beat < 0) begin
         exp_cnt[ch] = exp_cnt[ch] + 1'b1;
         p.ch = ch; p.edge_no = g + 2 + NBEATS; p.hdr = hdr; p.pld = pld; p.cnt = exp_cnt[ch];
         pq.push_back(p);
      end
      tick();
      gnt[ch] = 1'b0;
      req[ch] = 1'b0;
      tick();
      put(ch, hdr, 1'b0);
      tick();
      for (int b = 0; b < NBEATS && !aborted; b++) begin
         put(ch, pld[b*DW +: DW], b == par_beat);
         if (b == ovl_beat) begin
            gnt[ch] = 1'b1;
            push_err(ch, cyc + 1, 3'd4);
         end
`ifdef SII_NCU_XFER_MON_PARITY_EN
         if (b == par_beat) push_err(ch, cyc + 1, 3'd5);
`endif
         if (b == rst_beat) iol2rst = 1'b1;
         tick();
         gnt[ch] = 1'b0;
         if (iol2rst) begin
            iol2rst = 1'b0;
            for (int c = 0; c < NCH; c++) exp_cnt[c] = '0;
            aborted = 1'b1;
         end
      end
      put(ch, '0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int c = 0; c < NCH; c++) exp_cnt[c] = '0;
      repeat (3) tick();
      iol2rst = 1'b0;
      enable  = 1'b1;
      chk("rst_pkt_vld",   256'(pkt_vld),   256'(0));
      chk("rst_err_pulse", 256'(err_pulse), 256'(0));
      chk("rst_pkt_hdr",   256'(pkt_hdr),   256'(0));
      chk("rst_pkt_pld",   256'(pkt_pld),   256'(0));
      chk("rst_err_code",  256'(err_code),  256'(0));
      chk("rst_xfer_cnt",  256'(xfer_cnt),  256'(0));
      repeat (2) tick();

      // Basic transfer on ch0; ch1 idle.
      send_pkt(0, 2, 32'hA5A5_0001, {32'h44, 32'h33, 32'h22, 32'h11}, -1, -1, -1);
      repeat (3) tick();
      chk("hold_hdr0", 256'(pkt_hdr[31:0]), 256'(32'hA5A5_0001));
      chk("cnt1_idle", 256'(xfer_cnt[2*CNT_W-1:CNT_W]), 256'(0));

      // Grant without request, then request dropped in REQ.
      push_err(1, cyc + 1, 3'd1);
      gnt[1] = 1'b1;
      tick();
      gnt[1] = 1'b0;
      repeat (3) tick();
      chk("err_code_hold1", 256'(err_code[5:3]), 256'(1));
      req[1] = 1'b1;
      tick();
      req[1] = 1'b0;
      push_err(1, cyc + 1, 3'd2);
      repeat (2) tick();
      push_err(1, cyc + 1, 3'd1);
      gnt[1] = 1'b1;
      tick();
      gnt[1] = 1'b0;
      repeat (2) tick();

      // Timeout flagged once, packet still completes.
      tmo_limit = 8'd5;
      send_pkt(0, 9, 32'hB0B0_0002, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, -1, -1, -1);
      tmo_limit = '0;
      repeat (2) tick();

      // Grant overlap during payload.
      send_pkt(0, 1, 32'hC0C0_0003, {32'h1004, 32'h1003, 32'h1002, 32'h1001}, 2, -1, -1);
      repeat (2) tick();

      // Flipped parity on beat 2.
      send_pkt(0, 0, 32'hD0D0_0004, {32'hFFFF_0000, 32'h1234_5678, 32'h8000_0001, 32'h0F0F_F0F0}, -1, 2, -1);
      repeat (2) tick();

      // Disabled monitor ignores an illegal grant.
      enable = 1'b0;
      gnt[0] = 1'b1;
      tick();
      gnt[0] = 1'b0;
      enable = 1'b1;
      repeat (2) tick();

      // Reset during beat 1 discards the packet.
      send_pkt(0, 1, 32'hE0E0_0005, {32'h5, 32'h4, 32'h3, 32'h2}, -1, -1, 1);
      repeat (6) tick();
      chk("mid_rst_hdr", 256'(pkt_hdr),  256'(0));
      chk("mid_rst_pld", 256'(pkt_pld),  256'(0));
      chk("mid_rst_cnt", 256'(xfer_cnt), 256'(0));
      chk("mid_rst_err", 256'(err_code), 256'(0));
      send_pkt(0, 1, 32'hF0F0_0006, {32'h9, 32'h8, 32'h7, 32'h6}, -1, -1, -1);

      repeat (10) tick();
      chk("pkt_q_left", 256'(pq.size()), 256'(0));
      chk("err_q_left", 256'(eq.size()), 256'(0));
      chk("final_cnt0", 256'(xfer_cnt[CNT_W-1:0]), 256'(exp_cnt[0]));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sii_ncu_xfer_mon.md
# sii_ncu_xfer_mon

Synthesizable, parametrised successor to the simulation-only SII→NCU inbound monitor. It tracks NCH independent req/gnt/header/payload transfer channels on the iol2clk domain and captures each packet (header plus NBEATS payload beats). It checks handshake legality, request-to-grant timeout and optionally payload parity, and reports per-channel status and counters. It sits alongside the SII/NCU boundary and observes only; it never drives the bus.

## Interface
Parameters:
- NCH, 1, number of independent channels
- DW, 32, data bus width per channel; must be a multiple of 16
- PW, DW/16, parity bits per channel; one bit per 16-bit slice
- NBEATS, 4, payload beats per packet; minimum 1
- TMO_W, 8, timeout limit width
- CNT_W, 16, transfer counter width

Ports:
- iol2clk  in  1  sole clock
- iol2rst  in  1  synchronous, active-high reset
- enable  in  1  global enable
- req  in  NCH  per-channel request (SII→NCU)
- gnt  in  NCH  per-channel grant (NCU→SII)
- data  in  NCH*DW  per-channel data bus
- dparity  in  NCH*PW  per-channel data parity
- tmo_limit  in  TMO_W  maximum REQ cycles before timeout; 0 disables timeout
- pkt_vld  out  NCH  1-cycle pulse per completed packet
- pkt_hdr  out  NCH*DW  captured header, held until the next packet
- pkt_pld  out  NCH*NBEATS*DW  captured payload, beat 0 in LSBs, held
- err_pulse  out  NCH  1-cycle pulse on any error
- err_code  out  NCH*3  last error code, held
- xfer_cnt  out  NCH*CNT_W  completed packets, saturating

## Operation
- Per-channel FSM states: IDLE, REQ, GAP, HDR, PLD.
- IDLE:
  - req=1, gnt=0 → REQ; timeout counter is cleared.
  - req=1, gnt=1 → GAP; no error.
  - req=0, gnt=1 → error GNT_NO_REQ; stay in IDLE.
- REQ:
  - gnt=1 → GAP.
  - req=0 and gnt=0 → error REQ_DROP; go to IDLE.
  - Timeout counter increments each cycle. When tmo_limit≠0 and the counter equals tmo_limit → error TIMEOUT, flagged once; the FSM keeps waiting. The counter saturates.
- GAP: one ignored cycle → HDR.
- HDR: capture data into the header register → PLD; beat index = 0.
- PLD: capture data into beat[index]. On the last beat (index=NBEATS-1) → IDLE, assert pkt_vld on the next cycle, xfer_cnt +1 (saturating at all-ones).
- In GAP, HDR or PLD, gnt=1 → error GNT_OVERLAP and the grant is ignored. req level is not checked in these states.
- On returning to IDLE with req still high, the FSM re-enters REQ on the next cycle.
- Error codes: 0 NONE, 1 GNT_NO_REQ, 2 REQ_DROP, 3 TIMEOUT, 4 GNT_OVERLAP, 5 PARITY. If two errors occur in the same cycle, the higher code wins.
- enable=0: all FSMs are forced to IDLE with no pulses; held outputs and counters are frozen.

## Timing
- gnt sampled high in cycle C:
  - GAP in C+1.
  - Header sampled in C+2.
  - Payload beats sampled in C+3 … C+2+NBEATS.
  - pkt_vld, updated pkt_hdr/pkt_pld and xfer_cnt are visible in C+3+NBEATS.
- err_pulse and err_code are registered and appear one cycle after the offending sample.
- Reset values: all FSMs IDLE; pkt_vld, err_pulse, pkt_hdr, pkt_pld, err_code and xfer_cnt are 0.
- Reset mid-transfer: the partial packet is discarded and no pkt_vld is raised.
- Minimum back-to-back spacing: a gnt in the cycle after the last payload beat is legal (IDLE with req=1).

## Configuration
- SII_NCU_XFER_MON_PARITY_EN defined:
  - On each payload beat, check dparity[i] == ^data[16i+15:16i] for every slice i.
  - Any mismatch → error PARITY (code 5).
  - The packet is still delivered and counted.
- Undefined: dparity is ignored and code 5 is never produced.

## Structure
- Package sii_ncu_mon_pkg holds:
  - the FSM state enum
  - the error-code constants
  - the parity slice width constant (16)
- Sub-module sii_ncu_xfer_chan implements one channel (FSM, capture registers, timeout, counter, parity). The top generate-instantiates it NCH times and concatenates the outputs.

## Test plan
- NCH=2, NBEATS=4. Ch0: req, gnt at C=10, header 0xA5A5_0001, beats 0x11,0x22,0x33,0x44 → pkt_vld at cycle 17 with matching hdr/pld, xfer_cnt[0]=1. Ch1 stays idle.
- gnt with req=0 → err_code=1 and one err_pulse. req dropped in REQ → code 2, FSM back in IDLE.
- tmo_limit=5, req held with no gnt → code 3 exactly once, 6 cycles after REQ entry. A later gnt completes the packet normally.
- gnt pulsed during PLD → code 4. The packet still completes with the correct data.
- PARITY_EN defined, beat 2 with a flipped parity bit → code 5 one cycle later, pkt_vld still asserted. With PARITY_EN undefined → no error.
- iol2rst asserted during beat 1 → no pkt_vld, outputs 0. The next full transfer completes correctly.
